// File: rtl/dwc_error_monitor_if.sv
// Sample/status bundle between a DwC cell's consumer side and dwc_error_monitor.
// master drives samples and clear; slave (the monitor) drives status outputs.
interface dwc_error_monitor_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic             port_valid;
  logic [WIDTH-1:0] port_in;
  logic             port_error;
  logic             port_clear;
  logic [WIDTH-1:0] port_out;
  logic             port_out_valid;
  logic [1:0]       port_state;
  logic             port_alarm;
  logic [CNT_W-1:0] port_err_count;

  modport master (
    output port_valid, port_in, port_error, port_clear,
    input  port_out, port_out_valid, port_state, port_alarm, port_err_count
  );

  modport slave (
    input  port_valid, port_in, port_error, port_clear,
    output port_out, port_out_valid, port_state, port_alarm, port_err_count
  );
endinterface

// File: rtl/dwc_error_monitor.sv
// Fault monitor downstream of a duplication-with-comparison cell.
// Forwards only samples that passed comparison, holds the last good value through
// transient mismatches, latches an alarm after THRESH consecutive mismatches and keeps
// a saturating mismatch count.
// Optional: define DWC_MON_STICKY_EN to make FAULT exit only through rst_n.
module dwc_error_monitor #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  dwc_error_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    StOk      = 2'b00,
    StSuspect = 2'b01,
    StFault   = 2'b10
  } state_e;

  localparam logic [7:0] ThreshRun = 8'(THRESH);

  state_e           state_q;
  logic [7:0]       run_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             alarm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       run_inc;
  logic             clear_take;

  // Clear acceptance; in sticky builds a latched fault ignores clear.
  always_comb begin
    run_inc = run_q + 8'd1;
`ifdef DWC_MON_STICKY_EN
    clear_take = mon.port_clear && (state_q != StFault);
`else
    clear_take = mon.port_clear;
`endif
  end

  // State machine with all outputs registered; clear beats a same-cycle sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StOk;
      run_q       <= 8'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (clear_take) begin
        state_q <= StOk;
        run_q   <= 8'd0;
        alarm_q <= 1'b0;
        cnt_q   <= '0;
      end else if (mon.port_valid) begin
        if (mon.port_error && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        unique case (state_q)
          StOk: begin
            if (mon.port_error) begin
              run_q <= 8'd1;
              if (THRESH == 1) begin
                state_q <= StFault;
                alarm_q <= 1'b1;
              end else begin
                state_q <= StSuspect;
              end
            end else begin
              out_q       <= mon.port_in;
              out_valid_q <= 1'b1;
            end
          end
          StSuspect: begin
            if (mon.port_error) begin
              run_q <= run_inc;
              if (run_inc == ThreshRun) begin
                state_q <= StFault;
                alarm_q <= 1'b1;
              end
            end else begin
              state_q     <= StOk;
              run_q       <= 8'd0;
              out_q       <= mon.port_in;
              out_valid_q <= 1'b1;
            end
          end
          StFault: begin
            // Output frozen; only clear or reset leaves this state.
          end
          default: begin
            state_q <= StOk;
            run_q   <= 8'd0;
            alarm_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mon.port_out       = out_q;
  assign mon.port_out_valid = out_valid_q;
  assign mon.port_state     = state_q;
  assign mon.port_alarm     = alarm_q;
  assign mon.port_err_count = cnt_q;

endmodule
